matmul_tiled_engine: RTL and testbench
======================================

// Module: matmul_tiled_engine
// PURPOSE
//   Parametrised signed-integer matrix-multiply engine computing C[MxN] = A[MxK] * B[KxN].
//   Output-stationary broadcast PE array of PE_ROWS x PE_COLS MACs; C is processed tile by tile.
//   A and B are stored in row-/column-banked on-chip memories, loaded by the host.
//   C is streamed out over a valid/ready port; a cycle counter records compute latency for metrics.
// PARAMETERS
//   M          64  rows of A / C; must be a multiple of PE_ROWS
//   K          64  inner dimension, >=1
//   N          64  columns of B / C; must be a multiple of PE_COLS
//   IN_WIDTH    8  signed operand width
//   ACC_WIDTH  32  signed accumulator / result width
//   PE_ROWS     4  PE array rows (A banks: row i in bank i%PE_ROWS)
//   PE_COLS     4  PE array cols (B banks: col j in bank j%PE_COLS)
// PORTS
//   clk        in   1                       clock
//   rst_n      in   1                       async active-low reset
//   ld_we      in   1                       host write strobe
//   ld_sel     in   1                       0 = A, 1 = B
//   ld_row     in   $clog2(max(M,K))        A: row i; B: row k
//   ld_col     in   $clog2(max(K,N))        A: col k; B: col j
//   ld_data    in   IN_WIDTH                signed element
//   start      in   1                       begin multiply (sampled in IDLE only)
//   busy       out  1                       high from accepted start until done
//   done       out  1                       one-cycle pulse after last C element accepted
//   c_valid    out  1                       result element valid
//   c_ready    in   1                       sink ready
//   c_data     out  ACC_WIDTH               C[c_row][c_col]
//   c_row      out  $clog2(M)               row index of c_data
//   c_col      out  $clog2(N)               col index of c_data
//   cycle_cnt  out  32                      cycles from start accept to done
// BEHAVIOUR
//   Reset (async, rst_n=0): FSM=IDLE; busy, done, c_valid=0; c_data, c_row, c_col, cycle_cnt=0;
//     accumulators=0. Memory contents undefined after reset. Reset mid-run aborts with no done pulse.
//   Load: ld_we writes ld_data to element (ld_row,ld_col) in 1 cycle; accepted only in IDLE, ignored when busy.
//     Out-of-range indices are ignored.
//   FSM: IDLE -> CLEAR -> FEED -> FLUSH -> DRAIN -> (CLEAR for next tile | FIN) ; FIN -> IDLE.
//     IDLE : start=1 -> CLEAR; tile (ti,tj)=(0,0); cycle_cnt<=0; busy<=1.
//     CLEAR: 1 cycle; all accumulators <= 0; k<=0.
//     FEED : K cycles; each cycle reads A[ti*PE_ROWS+r][k] from every A bank and B[k][tj*PE_COLS+c]
//            from every B bank (1-cycle read latency); k increments.
//     FLUSH: 1 cycle; the final read is accumulated. PE(r,c): acc <= acc + a[r]*b[c].
//     DRAIN: emits PE_ROWS*PE_COLS elements, row-major within the tile (r outer, c inner).
//            c_valid held with c_data/c_row/c_col stable until c_valid&c_ready; zero-bubble when c_ready=1.
//            After last beat: next tile tj+1, wrapping to tj=0, ti+1; after the final tile -> FIN.
//     FIN  : done=1 for exactly 1 cycle, busy<=0, cycle_cnt frozen; then IDLE.
//   Arithmetic: product is signed 2*IN_WIDTH, sign-extended to ACC_WIDTH; accumulation wraps
//     modulo 2^ACC_WIDTH (no saturation).
//   Latency: per tile 1+K+1 cycles plus DRAIN beats; with c_ready=1 the total cycle count is
//     (M/PE_ROWS)*(N/PE_COLS)*(K+2+PE_ROWS*PE_COLS)+1.
//   cycle_cnt increments every cycle while busy=1 and holds its value in IDLE until the next start.
//   start while busy is ignored; start coincident with ld_we in IDLE gives priority to start
//     (the write is dropped).
// TESTING
//   1. M=K=N=4, PE 2x2, A=I, B=k*4+j -> C==B, 16 beats row-major per tile, one done pulse.
//   2. A all -128, B all -128, K=64 -> every C = 1048576 (no overflow, ACC_WIDTH=32).
//   3. ACC_WIDTH=16, A=B=127, K=4 -> C = 64516 mod 2^16 = -1020 (signed wrap).
//   4. c_ready random 50% -> c_data/c_row/c_col stable while stalled, no lost or duplicated beats.
//   5. c_ready=1, M=K=N=8, PE 4x4 -> cycle_cnt == 4*(8+2+16)+1 = 105.
//   6. rst_n low mid-FEED -> busy=0, c_valid=0, no done; new start then gives a correct C.
//   7. ld_we during busy -> memory unchanged; start while busy -> ignored.

Source files
------------

// File: rtl/matmul_tiled_engine_if.sv
// Host-side bundle for matmul_tiled_engine: operand load port, start/busy/done control,
//   the C result stream (valid/ready) and the compute-latency counter.
// master: host/sink side (drives loads, start, c_ready); slave: engine side.
interface matmul_tiled_engine_if #(
  parameter int M         = 64,
  parameter int K         = 64,
  parameter int N         = 64,
  parameter int IN_WIDTH  = 8,
  parameter int ACC_WIDTH = 32
);
  localparam int LD_ROW_W = $clog2((M > K) ? M : K);
  localparam int LD_COL_W = $clog2((K > N) ? K : N);
  localparam int C_ROW_W  = $clog2(M);
  localparam int C_COL_W  = $clog2(N);

  logic                        ld_we;
  logic                        ld_sel;
  logic [LD_ROW_W-1:0]         ld_row;
  logic [LD_COL_W-1:0]         ld_col;
  logic signed [IN_WIDTH-1:0]  ld_data;
  logic                        start;
  logic                        busy;
  logic                        done;
  logic                        c_valid;
  logic                        c_ready;
  logic signed [ACC_WIDTH-1:0] c_data;
  logic [C_ROW_W-1:0]          c_row;
  logic [C_COL_W-1:0]          c_col;
  logic [31:0]                 cycle_cnt;

  modport master (
    output ld_we, ld_sel, ld_row, ld_col, ld_data, start, c_ready,
    input  busy, done, c_valid, c_data, c_row, c_col, cycle_cnt
  );

  modport slave (
    input  ld_we, ld_sel, ld_row, ld_col, ld_data, start, c_ready,
    output busy, done, c_valid, c_data, c_row, c_col, cycle_cnt
  );
endinterface

// File: rtl/matmul_tiled_engine.sv
// Tiled signed matrix multiply C = A*B on a PE_ROWS x PE_COLS output-stationary broadcast array.
// Latency: per tile 1 (clear) + K (feed) + 1 (flush) + PE_ROWS*PE_COLS drain beats; +1 finish cycle.
// Backpressure: c_ready low stalls DRAIN with c_data/c_row/c_col held; loads ignored while busy.
// Ports: clk, rst_n (async active-low), bus = matmul_tiled_engine_if.slave (load, control, C stream).
module matmul_tiled_engine #(
  parameter int M         = 64,
  parameter int K         = 64,
  parameter int N         = 64,
  parameter int IN_WIDTH  = 8,
  parameter int ACC_WIDTH = 32,
  parameter int PE_ROWS   = 4,
  parameter int PE_COLS   = 4
) (
  input logic              clk,
  input logic              rst_n,
  matmul_tiled_engine_if.slave bus
);
  localparam int TILES_R = M / PE_ROWS;
  localparam int TILES_C = N / PE_COLS;
  localparam int A_DEPTH = TILES_R * K;
  localparam int B_DEPTH = TILES_C * K;
  localparam int A_AW    = (A_DEPTH > 1) ? $clog2(A_DEPTH) : 1;
  localparam int B_AW    = (B_DEPTH > 1) ? $clog2(B_DEPTH) : 1;
  localparam int K_W     = (K > 1) ? $clog2(K) : 1;
  localparam int TR_W    = (TILES_R > 1) ? $clog2(TILES_R) : 1;
  localparam int TC_W    = (TILES_C > 1) ? $clog2(TILES_C) : 1;
  localparam int PR_W    = (PE_ROWS > 1) ? $clog2(PE_ROWS) : 1;
  localparam int PC_W    = (PE_COLS > 1) ? $clog2(PE_COLS) : 1;
  localparam int C_ROW_W = $clog2(M);
  localparam int C_COL_W = $clog2(N);
  localparam int PROD_W  = 2 * IN_WIDTH;

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DRAIN, FIN} state_t;

  state_t                      state;
  logic [K_W-1:0]              k_idx;
  logic [TR_W-1:0]             ti;
  logic [TC_W-1:0]             tj;
  logic [PR_W-1:0]             dr;
  logic [PC_W-1:0]             dc;
  logic                        busy_q, done_q, c_valid_q;
  logic signed [ACC_WIDTH-1:0] c_data_q;
  logic [C_ROW_W-1:0]          c_row_q;
  logic [C_COL_W-1:0]          c_col_q;
  logic [31:0]                 cycle_cnt_q;

  // Bank r of A holds rows r, r+PE_ROWS, ...; each row occupies K consecutive words.
  // Bank c of B holds columns c, c+PE_COLS, ...; each column occupies K consecutive words.
  logic signed [IN_WIDTH-1:0]  a_mem [PE_ROWS][A_DEPTH];
  logic signed [IN_WIDTH-1:0]  b_mem [PE_COLS][B_DEPTH];
  logic signed [IN_WIDTH-1:0]  a_rd  [PE_ROWS];
  logic signed [IN_WIDTH-1:0]  b_rd  [PE_COLS];
  logic signed [ACC_WIDTH-1:0] acc   [PE_ROWS][PE_COLS];
  logic signed [PROD_W-1:0]    prod  [PE_ROWS][PE_COLS];

  logic             wr_ok, a_wr, b_wr, acc_en, last_beat, last_tile;
  logic [PR_W-1:0]  a_wbank, nr;
  logic [PC_W-1:0]  b_wbank, nc;
  logic [A_AW-1:0]  a_waddr, a_raddr;
  logic [B_AW-1:0]  b_waddr, b_raddr;

  always_comb begin
    // start wins over a coincident write; out-of-range indices are dropped.
    wr_ok   = bus.ld_we && !bus.start && (state == IDLE);
    a_wr    = wr_ok && !bus.ld_sel && (int'(bus.ld_row) < M) && (int'(bus.ld_col) < K);
    b_wr    = wr_ok &&  bus.ld_sel && (int'(bus.ld_row) < K) && (int'(bus.ld_col) < N);
    a_wbank = PR_W'(int'(bus.ld_row) % PE_ROWS);
    a_waddr = A_AW'((int'(bus.ld_row) / PE_ROWS) * K + int'(bus.ld_col));
    b_wbank = PC_W'(int'(bus.ld_col) % PE_COLS);
    b_waddr = B_AW'((int'(bus.ld_col) / PE_COLS) * K + int'(bus.ld_row));
    a_raddr = A_AW'(int'(ti) * K + int'(k_idx));
    b_raddr = B_AW'(int'(tj) * K + int'(k_idx));
    // Reads land one cycle late: FEED k=0 has nothing yet, FLUSH takes the last one.
    acc_en  = ((state == FEED) && (k_idx != '0)) || (state == FLUSH);
    last_beat = (dr == PR_W'(PE_ROWS - 1)) && (dc == PC_W'(PE_COLS - 1));
    last_tile = (ti == TR_W'(TILES_R - 1)) && (tj == TC_W'(TILES_C - 1));
    nr = dr;
    nc = dc + PC_W'(1);
    if (dc == PC_W'(PE_COLS - 1)) begin
      nc = '0;
      nr = dr + PR_W'(1);
    end
    for (int r = 0; r < PE_ROWS; r++)
      for (int c = 0; c < PE_COLS; c++)
        prod[r][c] = PROD_W'(a_rd[r]) * PROD_W'(b_rd[c]);
  end

  // Operand storage and registered read ports; contents are not reset.
  always_ff @(posedge clk) begin
    if (a_wr) a_mem[a_wbank][a_waddr] <= bus.ld_data;
    if (b_wr) b_mem[b_wbank][b_waddr] <= bus.ld_data;
    for (int r = 0; r < PE_ROWS; r++) a_rd[r] <= a_mem[r][a_raddr];
    for (int c = 0; c < PE_COLS; c++) b_rd[c] <= b_mem[c][b_raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      k_idx       <= '0;
      ti          <= '0;
      tj          <= '0;
      dr          <= '0;
      dc          <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      c_valid_q   <= 1'b0;
      c_data_q    <= '0;
      c_row_q     <= '0;
      c_col_q     <= '0;
      cycle_cnt_q <= '0;
      for (int r = 0; r < PE_ROWS; r++)
        for (int c = 0; c < PE_COLS; c++)
          acc[r][c] <= '0;
    end else begin
      done_q <= 1'b0;
      if (busy_q) cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (acc_en)
        for (int r = 0; r < PE_ROWS; r++)
          for (int c = 0; c < PE_COLS; c++)
            acc[r][c] <= acc[r][c] + ACC_WIDTH'(prod[r][c]);
      case (state)
        IDLE: if (bus.start) begin
          state       <= CLEAR;
          ti          <= '0;
          tj          <= '0;
          cycle_cnt_q <= '0;
          busy_q      <= 1'b1;
        end
        CLEAR: begin
          for (int r = 0; r < PE_ROWS; r++)
            for (int c = 0; c < PE_COLS; c++)
              acc[r][c] <= '0;
          k_idx <= '0;
          state <= FEED;
        end
        FEED: begin
          if (k_idx == K_W'(K - 1)) state <= FLUSH;
          else k_idx <= k_idx + K_W'(1);
        end
        FLUSH: begin
          // acc[0][0] is still taking its final product this cycle, so forward it.
          c_valid_q <= 1'b1;
          c_data_q  <= acc[0][0] + ACC_WIDTH'(prod[0][0]);
          c_row_q   <= C_ROW_W'(int'(ti) * PE_ROWS);
          c_col_q   <= C_COL_W'(int'(tj) * PE_COLS);
          dr        <= '0;
          dc        <= '0;
          state     <= DRAIN;
        end
        DRAIN: if (c_valid_q && bus.c_ready) begin
          if (last_beat) begin
            c_valid_q <= 1'b0;
            if (last_tile) begin
              done_q <= 1'b1;
              state  <= FIN;
            end else begin
              if (tj == TC_W'(TILES_C - 1)) begin
                tj <= '0;
                ti <= ti + TR_W'(1);
              end else begin
                tj <= tj + TC_W'(1);
              end
              state <= CLEAR;
            end
          end else begin
            dr       <= nr;
            dc       <= nc;
            c_data_q <= acc[nr][nc];
            c_row_q  <= C_ROW_W'(int'(ti) * PE_ROWS + int'(nr));
            c_col_q  <= C_COL_W'(int'(tj) * PE_COLS + int'(nc));
          end
        end
        FIN: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.c_valid   = c_valid_q;
  assign bus.c_data    = c_data_q;
  assign bus.c_row     = c_row_q;
  assign bus.c_col     = c_col_q;
  assign bus.cycle_cnt = cycle_cnt_q;
endmodule

// File: tb/tb_matmul_tiled_engine.sv
// Bench for matmul_tiled_engine: two instances (8x8x8 on a 4x4 array with 32-bit acc,
//   4x64x4 on a 2x2 array with 16-bit acc); expected C beats queued from a reference
//   product at start, popped as each beat is accepted.
module tb_matmul_tiled_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matmul_tiled_engine_if #(.M(8), .K(8), .N(8), .IN_WIDTH(8), .ACC_WIDTH(32)) if0 ();
  matmul_tiled_engine_if #(.M(4), .K(64), .N(4), .IN_WIDTH(8), .ACC_WIDTH(16)) if1 ();

  matmul_tiled_engine #(.M(8), .K(8), .N(8), .IN_WIDTH(8), .ACC_WIDTH(32),
                        .PE_ROWS(4), .PE_COLS(4)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  matmul_tiled_engine #(.M(4), .K(64), .N(4), .IN_WIDTH(8), .ACC_WIDTH(16),
                        .PE_ROWS(2), .PE_COLS(2)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  typedef struct { int row; int col; longint data; } beat_t;
  beat_t q0[$];
  beat_t q1[$];

  int n_checks = 0;
  int n_fail   = 0;
  int a0 [8][8];
  int b0 [8][8];
  int a1 [4][64];
  int b1 [64][4];
  int done_cnt0 = 0;
  int done_cnt1 = 0;
  bit rand_rdy = 1'b0;
  bit stall0 = 1'b0;
  logic [63:0] hold0;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Sink ready for instance 0; instance 1 is always ready.
  always @(posedge clk) begin
    #1;
    if0.c_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  assign if1.c_ready = 1'b1;

  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      if (if0.done) done_cnt0++;
      if (stall0)
        chk("stall_hold", {25'd0, if0.c_valid, if0.c_row, if0.c_col, if0.c_data}, hold0);
      stall0 = if0.c_valid && !if0.c_ready;
      hold0  = {25'd0, if0.c_valid, if0.c_row, if0.c_col, if0.c_data};
      if (if0.c_valid && if0.c_ready) begin
        if (q0.size() == 0) chk("extra_beat0", 1, 0);
        else begin
          e = q0.pop_front();
          chk("c_data0", if0.c_data, e.data);
          chk("c_row0", if0.c_row, e.row);
          chk("c_col0", if0.c_col, e.col);
        end
      end
    end else begin
      stall0 = 1'b0;
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      if (if1.done) done_cnt1++;
      if (if1.c_valid && if1.c_ready) begin
        if (q1.size() == 0) chk("extra_beat1", 1, 0);
        else begin
          e = q1.pop_front();
          chk("c_data1", if1.c_data, e.data);
          chk("c_row1", if1.c_row, e.row);
          chk("c_col1", if1.c_col, e.col);
        end
      end
    end
  end

  // Expected beat order: tiles row-major, then row-major inside each tile.
  task automatic push_exp0();
    beat_t e;
    longint s;
    for (int ti = 0; ti < 2; ti++)
      for (int tj = 0; tj < 2; tj++)
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) begin
            e.row = ti * 4 + r;
            e.col = tj * 4 + c;
            s = 0;
            for (int k = 0; k < 8; k++) s += longint'(a0[e.row][k] * b0[k][e.col]);
            e.data = longint'(int'(s));
            q0.push_back(e);
          end
  endtask

  task automatic push_exp1();
    beat_t e;
    longint s;
    for (int ti = 0; ti < 2; ti++)
      for (int tj = 0; tj < 2; tj++)
        for (int r = 0; r < 2; r++)
          for (int c = 0; c < 2; c++) begin
            e.row = ti * 2 + r;
            e.col = tj * 2 + c;
            s = 0;
            for (int k = 0; k < 64; k++) s += longint'(a1[e.row][k] * b1[k][e.col]);
            e.data = longint'(shortint'(s));
            q1.push_back(e);
          end
  endtask

  task automatic load0();
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 8; k++) begin
        @(posedge clk); #1;
        if0.ld_we = 1'b1; if0.ld_sel = 1'b0;
        if0.ld_row = 3'(i); if0.ld_col = 3'(k); if0.ld_data = 8'(a0[i][k]);
      end
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 8; j++) begin
        @(posedge clk); #1;
        if0.ld_we = 1'b1; if0.ld_sel = 1'b1;
        if0.ld_row = 3'(k); if0.ld_col = 3'(j); if0.ld_data = 8'(b0[k][j]);
      end
    @(posedge clk); #1;
    if0.ld_we = 1'b0;
  endtask

  task automatic load1();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 64; k++) begin
        @(posedge clk); #1;
        if1.ld_we = 1'b1; if1.ld_sel = 1'b0;
        if1.ld_row = 6'(i); if1.ld_col = 6'(k); if1.ld_data = 8'(a1[i][k]);
      end
    for (int k = 0; k < 64; k++)
      for (int j = 0; j < 4; j++) begin
        @(posedge clk); #1;
        if1.ld_we = 1'b1; if1.ld_sel = 1'b1;
        if1.ld_row = 6'(k); if1.ld_col = 6'(j); if1.ld_data = 8'(b1[k][j]);
      end
    @(posedge clk); #1;
    if1.ld_we = 1'b0;
  endtask

  // poke: start coincides with a write in IDLE, then a write and a start land mid-run;
  // all must be ignored, so the reference product stays unchanged.
  task automatic run0(input bit poke, input bit chk_cnt);
    int d0;
    int cyc;
    push_exp0();
    d0 = done_cnt0;
    @(posedge clk); #1;
    if0.start = 1'b1;
    if (poke) begin
      if0.ld_we = 1'b1; if0.ld_sel = 1'b0; if0.ld_row = '0; if0.ld_col = '0; if0.ld_data = 8'sd55;
    end
    @(posedge clk); #1;
    if0.start = 1'b0; if0.ld_we = 1'b0;
    chk("run0_busy_on_start", if0.busy, 1);
    if (poke) begin
      repeat (4) @(posedge clk);
      #1;
      if0.start = 1'b1; if0.ld_we = 1'b1; if0.ld_sel = 1'b1;
      if0.ld_row = 3'd1; if0.ld_col = 3'd2; if0.ld_data = -8'sd77;
      @(posedge clk); #1;
      if0.start = 1'b0; if0.ld_we = 1'b0;
    end
    cyc = 0;
    while (done_cnt0 == d0 && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    chk("run0_timeout", cyc < 5000, 1);
    repeat (2) @(negedge clk);
    chk("run0_done_pulses", done_cnt0 - d0, 1);
    chk("run0_beats_left", q0.size(), 0);
    chk("run0_busy_after", if0.busy, 0);
    if (chk_cnt) chk("run0_cycle_cnt", if0.cycle_cnt, 105);
    q0.delete();
  endtask

  task automatic run1();
    int d1;
    int cyc;
    push_exp1();
    d1 = done_cnt1;
    @(posedge clk); #1;
    if1.start = 1'b1;
    @(posedge clk); #1;
    if1.start = 1'b0;
    cyc = 0;
    while (done_cnt1 == d1 && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    chk("run1_timeout", cyc < 5000, 1);
    repeat (2) @(negedge clk);
    chk("run1_done_pulses", done_cnt1 - d1, 1);
    chk("run1_beats_left", q1.size(), 0);
    chk("run1_cycle_cnt", if1.cycle_cnt, 4 * (64 + 2 + 4) + 1);
    q1.delete();
  endtask

  task automatic rand_fill0();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        a0[i][j] = int'($urandom_range(0, 255)) - 128;
        b0[i][j] = int'($urandom_range(0, 255)) - 128;
      end
  endtask

  initial begin
    int d0;
    if0.ld_we = 1'b0; if0.ld_sel = 1'b0; if0.ld_row = '0; if0.ld_col = '0;
    if0.ld_data = '0; if0.start = 1'b0;
    if1.ld_we = 1'b0; if1.ld_sel = 1'b0; if1.ld_row = '0; if1.ld_col = '0;
    if1.ld_data = '0; if1.start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", if0.busy, 0);
    chk("rst_done", if0.done, 0);
    chk("rst_c_valid", if0.c_valid, 0);
    chk("rst_c_data", if0.c_data, 0);
    chk("rst_c_row", if0.c_row, 0);
    chk("rst_c_col", if0.c_col, 0);
    chk("rst_cycle_cnt", if0.cycle_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 16-bit accumulator wrap: 4 * 127 * 127 = 64516 -> -1020.
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 64; k++) a1[i][k] = (k < 4) ? 127 : 0;
    for (int k = 0; k < 64; k++)
      for (int j = 0; j < 4; j++) b1[k][j] = 127;
    load1();
    run1();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 64; k++) begin
        a1[i][k] = int'($urandom_range(0, 255)) - 128;
        b1[k][i] = int'($urandom_range(0, 255)) - 128;
      end
    load1();
    run1();

    // Identity A: C must equal B.
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        a0[i][j] = (i == j) ? 1 : 0;
        b0[i][j] = i * 8 + j;
      end
    load0();
    run0(1'b0, 1'b1);

    // Most negative operands everywhere: 8 * 16384 = 131072.
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        a0[i][j] = -128;
        b0[i][j] = -128;
      end
    load0();
    run0(1'b0, 1'b1);

    // Random data under random sink backpressure.
    rand_fill0();
    load0();
    rand_rdy = 1'b1;
    run0(1'b0, 1'b0);
    rand_rdy = 1'b0;
    @(posedge clk);

    // Writes and start while busy / start with a write in IDLE are ignored.
    run0(1'b1, 1'b1);
    run0(1'b0, 1'b1);

    // Reset in the middle of FEED aborts without a done pulse.
    d0 = done_cnt0;
    @(posedge clk); #1;
    if0.start = 1'b1;
    @(posedge clk); #1;
    if0.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", if0.busy, 0);
    chk("midrst_c_valid", if0.c_valid, 0);
    chk("midrst_cycle_cnt", if0.cycle_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("midrst_no_done", done_cnt0 - d0, 0);
    chk("midrst_idle_busy", if0.busy, 0);
    rand_fill0();
    load0();
    run0(1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
